// File: rtl/noc_to_axi4_master.sv
// rtl/noc_to_axi4_master.sv - NoC response packets to AXI4 B/R response beats
module noc_to_axi4_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CNT_W-1:0] count_next
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = valid && ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module noc_to_axi4_master #(
    parameter int DATA_WIDTH   = 128,
    parameter int ID_WIDTH     = 4,
    parameter int AXI_ID_WIDTH = 4,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst,
    input  logic [DATA_WIDTH:0]     noc2axi_data,
    input  logic                    s_is_head,
    input  logic                    s_is_tail,
    output logic                    buffer_busy,
    output logic [AXI_ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0] s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;
    localparam logic [2:0] TYPE_WR = 3'b011;
    localparam logic [2:0] TYPE_RD = 3'b010;
    localparam int B_W   = AXI_ID_WIDTH + 2;
    localparam int R_W   = AXI_ID_WIDTH + 2 + DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BUSY_LEVEL = CNT_W'(BUFFER_DEPTH - 2);

    logic [DATA_WIDTH-1:0] flit;
    logic                  flit_valid;
    logic [ID_WIDTH-1:0]   f_id;
    logic [2:0]            f_type;
    logic [1:0]            f_resp;

    assign flit       = noc2axi_data[DATA_WIDTH-1:0];
    assign flit_valid = noc2axi_data[DATA_WIDTH];
    assign f_id       = flit[127 -: ID_WIDTH];
    assign f_type     = flit[115:113];
    assign f_resp     = flit[58:57];

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [2:0]            cur_type;
    logic [1:0]            cur_resp;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;

    logic                  b_push;
    logic [ID_WIDTH-1:0]   b_id_in;
    logic [1:0]            b_resp_in;
    logic                  r_push;
    logic                  r_last;
    logic [B_W-1:0]        b_dout;
    logic [R_W-1:0]        r_dout;
    logic [CNT_W-1:0]      b_count_next;
    logic [CNT_W-1:0]      r_count_next;

    always_comb begin
        b_push    = 1'b0;
        b_id_in   = cur_id;
        b_resp_in = cur_resp;
        r_push    = 1'b0;
        r_last    = 1'b0;
        if (flit_valid) begin
            if (s_is_head) begin
                // Head+tail in one flit is a zero-beat packet; write responses still emit B.
                if (s_is_tail && f_type == TYPE_WR) begin
                    b_push    = 1'b1;
                    b_id_in   = f_id;
                    b_resp_in = f_resp;
                end
            end else if (state == ST_PKT) begin
                r_push = (cur_type == TYPE_RD) && stage_valid;
                if (s_is_tail) begin
                    b_push = (cur_type == TYPE_WR);
                    r_last = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state       <= ST_IDLE;
            cur_id      <= '0;
            cur_type    <= '0;
            cur_resp    <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            buffer_busy <= 1'b0;
        end else begin
            buffer_busy <= (b_count_next >= BUSY_LEVEL) || (r_count_next >= BUSY_LEVEL);
            if (flit_valid) begin
                if (s_is_head) begin
                    cur_id      <= f_id;
                    cur_type    <= f_type;
                    cur_resp    <= f_resp;
                    stage_valid <= 1'b0;
                    state       <= s_is_tail ? ST_IDLE : ST_PKT;
                end else if (state == ST_PKT) begin
                    if (s_is_tail) begin
                        stage_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (cur_type == TYPE_RD) begin
                        stage_data  <= flit;
                        stage_valid <= 1'b1;
                    end
                end
            end
        end
    end

    noc_to_axi4_master_fifo #(.WIDTH(B_W), .DEPTH(BUFFER_DEPTH), .CNT_W(CNT_W)) u_b_fifo (
        .clk        (noc_clk),
        .rst        (noc_rst),
        .push       (b_push),
        .din        ({b_id_in[AXI_ID_WIDTH-1:0], b_resp_in}),
        .ready      (s_axi_bready),
        .dout       (b_dout),
        .valid      (s_axi_bvalid),
        .count_next (b_count_next)
    );

    noc_to_axi4_master_fifo #(.WIDTH(R_W), .DEPTH(BUFFER_DEPTH), .CNT_W(CNT_W)) u_r_fifo (
        .clk        (noc_clk),
        .rst        (noc_rst),
        .push       (r_push),
        .din        ({cur_id[AXI_ID_WIDTH-1:0], cur_resp, stage_data, r_last}),
        .ready      (s_axi_rready),
        .dout       (r_dout),
        .valid      (s_axi_rvalid),
        .count_next (r_count_next)
    );

    assign {s_axi_bid, s_axi_bresp} = b_dout;
    assign {s_axi_rid, s_axi_rresp, s_axi_rdata, s_axi_rlast} = r_dout;
endmodule

// File: tb/tb_noc_to_axi4_master.sv
// tb/tb_noc_to_axi4_master.sv - directed bench for noc_to_axi4_master
module tb_noc_to_axi4_master;
    logic         noc_clk = 1'b0;
    logic         noc_rst;
    logic [128:0] noc2axi_data;
    logic         s_is_head;
    logic         s_is_tail;
    logic         buffer_busy;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [3:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    int checks = 0;
    int failures = 0;

    always #5 noc_clk = ~noc_clk;

    noc_to_axi4_master dut (
        .noc_clk      (noc_clk),
        .noc_rst      (noc_rst),
        .noc2axi_data (noc2axi_data),
        .s_is_head    (s_is_head),
        .s_is_tail    (s_is_tail),
        .buffer_busy  (buffer_busy),
        .s_axi_bid    (s_axi_bid),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [3:0] id, input logic [3:0] src,
                                         input logic [2:0] typ, input logic [1:0] resp,
                                         input logic [3:0] kind);
        logic [127:0] w;
        w = '0;
        w[127:124] = id;
        w[123:120] = src;
        w[119:116] = 4'h0;
        w[115:113] = typ;
        w[58:57]   = resp;
        w[56:53]   = kind;
        return w;
    endfunction

    task automatic send(input logic h, input logic t, input logic [127:0] d);
        noc2axi_data = {1'b1, d};
        s_is_head = h;
        s_is_tail = t;
        @(posedge noc_clk);
        #1;
        noc2axi_data = '0;
        s_is_head = 1'b0;
        s_is_tail = 1'b0;
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        noc_rst = 1'b1;
        noc2axi_data = '0;
        s_is_head = 1'b0;
        s_is_tail = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b0;
        repeat (3) tick();
        noc_rst = 1'b0;

        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_busy", buffer_busy, 0);
        chk("rst_bid", s_axi_bid, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_rlast", s_axi_rlast, 0);

        // back-to-back write responses, bready high
        send(1, 0, hdr(4'd5, 4'd1, 3'b011, 2'b00, 4'hA));
        chk("wr_head_bvalid", s_axi_bvalid, 0);
        send(0, 0, 128'hDEAD);
        chk("wr_body_bvalid", s_axi_bvalid, 0);
        send(0, 1, hdr(4'd5, 4'd1, 3'b011, 2'b00, 4'hF));
        chk("wr_a_bvalid", s_axi_bvalid, 1);
        chk("wr_a_bid", s_axi_bid, 5);
        chk("wr_a_bresp", s_axi_bresp, 2'b00);
        send(1, 0, hdr(4'd5, 4'd3, 3'b011, 2'b01, 4'hA));
        chk("wr_a_popped", s_axi_bvalid, 0);
        send(0, 1, hdr(4'd5, 4'd3, 3'b011, 2'b01, 4'hF));
        chk("wr_b_bvalid", s_axi_bvalid, 1);
        chk("wr_b_bid", s_axi_bid, 5);
        chk("wr_b_bresp", s_axi_bresp, 2'b01);
        tick();
        chk("wr_b_popped", s_axi_bvalid, 0);

        // bready low: beat held stable
        s_axi_bready = 1'b0;
        send(1, 0, hdr(4'd5, 4'd1, 3'b011, 2'b10, 4'hA));
        send(0, 0, 128'h1);
        send(0, 1, hdr(4'd5, 4'd1, 3'b011, 2'b10, 4'hF));
        for (int i = 0; i < 10; i++) begin
            chk("hold_bvalid", s_axi_bvalid, 1);
            chk("hold_bid", s_axi_bid, 5);
            chk("hold_bresp", s_axi_bresp, 2'b10);
            tick();
        end
        s_axi_bready = 1'b1;
        chk("hold_still_valid", s_axi_bvalid, 1);
        tick();
        chk("hold_popped", s_axi_bvalid, 0);

        // head+tail zero-beat write response
        send(1, 1, hdr(4'd6, 4'd2, 3'b011, 2'b11, 4'hA));
        chk("ht_bvalid", s_axi_bvalid, 1);
        chk("ht_bid", s_axi_bid, 6);
        chk("ht_bresp", s_axi_bresp, 2'b11);
        tick();

        // read packet, drained afterwards
        send(1, 0, hdr(4'd3, 4'd1, 3'b010, 2'b00, 4'hA));
        send(0, 0, 128'h11);
        chk("rd_staged_rvalid", s_axi_rvalid, 0);
        send(0, 0, 128'h22);
        chk("rd_b1_rvalid", s_axi_rvalid, 1);
        chk("rd_b1_rid", s_axi_rid, 3);
        send(0, 0, 128'h33);
        send(0, 1, hdr(4'd3, 4'd1, 3'b010, 2'b00, 4'hF));
        s_axi_rready = 1'b1;
        chk("rd_d0", s_axi_rdata, 128'h11);
        chk("rd_l0", s_axi_rlast, 0);
        chk("rd_resp", s_axi_rresp, 2'b00);
        tick();
        chk("rd_d1", s_axi_rdata, 128'h22);
        chk("rd_l1", s_axi_rlast, 0);
        tick();
        chk("rd_d2", s_axi_rdata, 128'h33);
        chk("rd_l2", s_axi_rlast, 1);
        chk("rd_rid2", s_axi_rid, 3);
        tick();
        chk("rd_empty", s_axi_rvalid, 0);

        // tail without body, then abort by a new head
        send(1, 0, hdr(4'd1, 4'd1, 3'b010, 2'b00, 4'hA));
        send(0, 1, hdr(4'd1, 4'd1, 3'b010, 2'b00, 4'hF));
        chk("nobody_rvalid", s_axi_rvalid, 0);
        send(1, 0, hdr(4'd1, 4'd1, 3'b010, 2'b00, 4'hA));
        send(0, 0, 128'hAA);
        send(1, 0, hdr(4'd2, 4'd1, 3'b010, 2'b01, 4'hA));
        chk("abort_rvalid", s_axi_rvalid, 0);
        send(0, 0, 128'hBB);
        s_axi_rready = 1'b0;
        send(0, 1, hdr(4'd2, 4'd1, 3'b010, 2'b01, 4'hF));
        chk("abort_rdata", s_axi_rdata, 128'hBB);
        chk("abort_rid", s_axi_rid, 2);
        chk("abort_rresp", s_axi_rresp, 2'b01);
        chk("abort_rlast", s_axi_rlast, 1);
        s_axi_rready = 1'b1;
        tick();
        chk("abort_empty", s_axi_rvalid, 0);

        // overflow with rready low
        s_axi_rready = 1'b0;
        send(1, 0, hdr(4'd7, 4'd1, 3'b010, 2'b10, 4'hA));
        for (int i = 1; i <= 10; i++) begin
            send(0, 0, 128'(i));
            if (i == 6) chk("ovf_busy_b6", buffer_busy, 0);
            if (i == 7) chk("ovf_busy_b7", buffer_busy, 1);
        end
        send(0, 1, hdr(4'd7, 4'd1, 3'b010, 2'b10, 4'hF));
        chk("ovf_busy_full", buffer_busy, 1);
        s_axi_rready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_rvalid", s_axi_rvalid, 1);
            chk("ovf_rdata", s_axi_rdata, 128'(i));
            chk("ovf_rlast", s_axi_rlast, 0);
            chk("ovf_rid", s_axi_rid, 7);
            chk("ovf_rresp", s_axi_rresp, 2'b10);
            tick();
            if (i == 2) chk("ovf_busy_at6", buffer_busy, 1);
            if (i == 3) chk("ovf_busy_at5", buffer_busy, 0);
        end
        chk("ovf_drained", s_axi_rvalid, 0);
        chk("ovf_busy_end", buffer_busy, 0);

        // reset mid-packet
        send(1, 0, hdr(4'd9, 4'd1, 3'b011, 2'b00, 4'hA));
        send(0, 0, 128'h5);
        noc_rst = 1'b1;
        tick();
        noc_rst = 1'b0;
        send(0, 1, hdr(4'd9, 4'd1, 3'b011, 2'b00, 4'hF));
        chk("mrst_bvalid", s_axi_bvalid, 0);
        send(1, 0, hdr(4'd8, 4'd1, 3'b010, 2'b00, 4'hA));
        send(0, 0, 128'h66);
        noc_rst = 1'b1;
        tick();
        noc_rst = 1'b0;
        send(0, 0, 128'h77);
        send(0, 1, hdr(4'd8, 4'd1, 3'b010, 2'b00, 4'hF));
        chk("mrst_rvalid", s_axi_rvalid, 0);
        send(1, 0, hdr(4'd4, 4'd2, 3'b011, 2'b11, 4'hA));
        send(0, 1, hdr(4'd4, 4'd2, 3'b011, 2'b11, 4'hF));
        chk("post_rst_bvalid", s_axi_bvalid, 1);
        chk("post_rst_bid", s_axi_bid, 4);
        chk("post_rst_bresp", s_axi_bresp, 2'b11);
        tick();
        chk("post_rst_popped", s_axi_bvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
